// File: rtl/stopwatch_pkg.sv
// Purpose: shared encodings and field widths for the stopwatch time counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stopwatch_pkg;

    localparam int TENTHS_W = 4;
    localparam int SEC_W    = 6;
    localparam int MIN_W    = 6;

    localparam logic [TENTHS_W-1:0] TENTHS_MAX = 4'd9;
    localparam logic [SEC_W-1:0]    SEC_MAX    = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    // Packed snapshot of the displayed time, used by the lap bank.
    typedef struct packed {
        logic [MIN_W-1:0]    min;
        logic [SEC_W-1:0]    sec;
        logic [TENTHS_W-1:0] tenths;
    } sw_time_t;

endpackage

// File: rtl/tick_edge_sync.sv
// Purpose: synchronise the divider's 10 Hz square wave and emit a 1-cycle pulse per rising edge.
// Latency: pulse is registered, SYNC_STAGES+1 clk cycles after tick_clk_i rises.
// Backpressure: none; every detected rising edge produces exactly one pulse.
// Ports: clk, reset_n (async active-low), tick_clk_i (async data in), tick_o (pulse out).
module tick_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_clk_i,
    output logic tick_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   prev_q;
    logic                   armed_q;
    logic                   tick_q;

    // prime_q walks a 1 through the chain alongside the data; armed_q only rises once
    // prev_q holds a genuinely sampled level, so a wave that was already high at reset
    // release does not look like a rising edge while the chain refills.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            prime_q <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], tick_clk_i};
            prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= sync_q[SYNC_STAGES-1];
            armed_q <= prime_q[SYNC_STAGES-1];
            tick_q  <= armed_q & sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/stopwatch_time_counter.sv
// Purpose: count elapsed tenths/seconds/minutes from divider ticks under a run/pause/clear FSM.
// Latency: o_tick 3 clk after i_tick_clk rises (default); time outputs update 1 clk after o_tick.
// Backpressure: none; buttons are single-cycle pulses, clear has priority over run and tick.
// Ports: clk, reset_n, i_tick_clk, i_run_btn, i_clear_btn, i_lap_btn ->
//        o_tenths, o_sec, o_min, o_running, o_tick, o_overflow.
// Option: define STOPWATCH_LAP_EN to build the lap freeze bank; otherwise i_lap_btn is ignored.
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MIN     = 59
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_tick_clk,
    input  logic                i_run_btn,
    input  logic                i_clear_btn,
    input  logic                i_lap_btn,
    output logic [TENTHS_W-1:0] o_tenths,
    output logic [SEC_W-1:0]    o_sec,
    output logic [MIN_W-1:0]    o_min,
    output logic                o_running,
    output logic                o_tick,
    output logic                o_overflow
);

    localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MAX_MIN);

    logic                tick;
    sw_state_e           state_q;
    logic                running_q;
    logic [TENTHS_W-1:0] tenths_q, tenths_d;
    logic [SEC_W-1:0]    sec_q,    sec_d;
    logic [MIN_W-1:0]    min_q,    min_d;
    logic                ovf_q,    ovf_d;

    tick_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tick_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick_clk_i (i_tick_clk),
        .tick_o     (tick)
    );

    // Run/pause/clear FSM. running_q is decoded from the next state so o_running
    // comes straight from a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
        end else if (i_clear_btn) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
        end else if (i_run_btn) begin
            case (state_q)
                ST_RUN: begin
                    state_q   <= ST_PAUSE;
                    running_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_RUN;
                    running_q <= 1'b1;
                end
            endcase
        end
    end

    // Cascaded counters. The count decision uses the current state, so a tick that
    // coincides with a run press is counted in RUN and ignored in PAUSE/IDLE.
    always_comb begin
        tenths_d = tenths_q;
        sec_d    = sec_q;
        min_d    = min_q;
        ovf_d    = 1'b0;
        if (i_clear_btn) begin
            tenths_d = '0;
            sec_d    = '0;
            min_d    = '0;
        end else if ((state_q == ST_RUN) && tick) begin
            if (tenths_q == TENTHS_MAX) begin
                tenths_d = '0;
                if (sec_q == SEC_MAX) begin
                    sec_d = '0;
                    if (min_q == MIN_LAST) begin
                        min_d = '0;
                        ovf_d = 1'b1;
                    end else begin
                        min_d = min_q + MIN_W'(1);
                    end
                end else begin
                    sec_d = sec_q + SEC_W'(1);
                end
            end else begin
                tenths_d = tenths_q + TENTHS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tenths_q <= '0;
            sec_q    <= '0;
            min_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            tenths_q <= tenths_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic     lap_act_q;
    sw_time_t lap_time_q;

    // Freeze holds the time shown when lap was pressed; the live counters keep going.
    // Leaving RUN via the run button, a second lap press, or clear all release it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_act_q  <= 1'b0;
            lap_time_q <= '0;
        end else if (i_clear_btn) begin
            lap_act_q  <= 1'b0;
        end else if (i_run_btn && (state_q == ST_RUN)) begin
            lap_act_q  <= 1'b0;
        end else if (i_lap_btn && lap_act_q) begin
            lap_act_q  <= 1'b0;
        end else if (i_lap_btn && (state_q == ST_RUN)) begin
            lap_act_q  <= 1'b1;
            lap_time_q <= '{min: min_q, sec: sec_q, tenths: tenths_q};
        end
    end

    assign o_tenths = lap_act_q ? lap_time_q.tenths : tenths_q;
    assign o_sec    = lap_act_q ? lap_time_q.sec    : sec_q;
    assign o_min    = lap_act_q ? lap_time_q.min    : min_q;
`else
    // Lap input has no function in this build; tie it off so it is not left dangling.
    logic unused_lap_btn;
    assign unused_lap_btn = i_lap_btn;

    assign o_tenths = tenths_q;
    assign o_sec    = sec_q;
    assign o_min    = min_q;
`endif

    assign o_running  = running_q;
    assign o_tick     = tick;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Purpose: directed, scoreboard-checked bench for stopwatch_time_counter (MAX_MIN=1).
// Latency: n/a.
// Backpressure: n/a.
module tb_stopwatch_time_counter;

    localparam int MAX_MIN = 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_tick_clk;
    logic       i_run_btn;
    logic       i_clear_btn;
    logic       i_lap_btn;
    logic [3:0] o_tenths;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic       o_running;
    logic       o_tick;
    logic       o_overflow;

    stopwatch_time_counter #(
        .SYNC_STAGES (2),
        .MAX_MIN     (MAX_MIN)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_tick_clk  (i_tick_clk),
        .i_run_btn   (i_run_btn),
        .i_clear_btn (i_clear_btn),
        .i_lap_btn   (i_lap_btn),
        .o_tenths    (o_tenths),
        .o_sec       (o_sec),
        .o_min       (o_min),
        .o_running   (o_running),
        .o_tick      (o_tick),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int s;
        int m;
        int run;
        int ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   tick_cnt = 0;
    int   ovf_cnt  = 0;

    // Reference model state
    int m_state = 0;   // 0 idle, 1 run, 2 pause
    int m_t = 0, m_s = 0, m_m = 0, m_ovf = 0;
    int lap_act = 0, f_t = 0, f_s = 0, f_m = 0;

    always @(negedge clk) begin
        if (o_tick === 1'b1)     tick_cnt++;
        if (o_overflow === 1'b1) ovf_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle of the reference behaviour for the given inputs.
    task automatic model_cycle(input bit tick, input bit run, input bit clr, input bit lap);
        m_ovf = 0;
        if (clr) begin
            m_state = 0; m_t = 0; m_s = 0; m_m = 0; lap_act = 0;
        end else begin
`ifdef STOPWATCH_LAP_EN
            if (run && m_state == 1)         lap_act = 0;
            else if (lap && lap_act == 1)    lap_act = 0;
            else if (lap && m_state == 1) begin
                lap_act = 1; f_t = m_t; f_s = m_s; f_m = m_m;
            end
`else
            if (lap) lap_act = 0;
`endif
            if (tick && m_state == 1) begin
                m_t++;
                if (m_t == 10) begin
                    m_t = 0; m_s++;
                    if (m_s == 60) begin
                        m_s = 0; m_m++;
                        if (m_m > MAX_MIN) begin m_m = 0; m_ovf = 1; end
                    end
                end
            end
            if (run) m_state = (m_state == 1) ? 2 : 1;
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.t   = lap_act ? f_t : m_t;
        e.s   = lap_act ? f_s : m_s;
        e.m   = lap_act ? f_m : m_m;
        e.run = (m_state == 1) ? 1 : 0;
        e.ovf = m_ovf;
        sb.push_back(e);
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_tenths"},  32'(o_tenths),   e.t);
            chk({tag, "_sec"},     32'(o_sec),      e.s);
            chk({tag, "_min"},     32'(o_min),      e.m);
            chk({tag, "_running"}, 32'(o_running),  e.run);
            chk({tag, "_ovf"},     32'(o_overflow), e.ovf);
        end
    endtask

    // Drive one cycle of buttons, optionally aligned with a divider tick pulse.
    task automatic do_event(input bit tick, input bit run, input bit clr, input bit lap,
                            input string tag, input bit full_chk);
        bit seen;
        seen = 0;
        if (tick) begin
            i_tick_clk = 1'b1;
            for (int k = 0; k < 8 && !seen; k++) begin
                @(negedge clk);
                if (o_tick === 1'b1) seen = 1;
            end
            if (!seen) chk({tag, "_tick_seen"}, 32'(seen), 1);
        end else begin
            @(negedge clk);
        end
        i_run_btn   = run;
        i_clear_btn = clr;
        i_lap_btn   = lap;
        model_cycle(tick && seen, run, clr, lap);
        push_expect();
        @(posedge clk);
        #1;
        i_run_btn   = 1'b0;
        i_clear_btn = 1'b0;
        i_lap_btn   = 1'b0;
        @(negedge clk);
        if (full_chk) check_sb(tag);
        else begin
            exp_t e;
            e = sb.pop_front();
            chk({tag, "_tenths"}, 32'(o_tenths), e.t);
            chk({tag, "_ovf"},    32'(o_overflow), e.ovf);
        end
        if (tick) begin
            i_tick_clk = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) do_event(1'b1, 1'b0, 1'b0, 1'b0, tag, 1'b0);
    endtask

    task automatic chk_time(input string tag, input int mm, input int ss, input int tt);
        chk({tag, "_min"},    32'(o_min),    mm);
        chk({tag, "_sec"},    32'(o_sec),    ss);
        chk({tag, "_tenths"}, 32'(o_tenths), tt);
    endtask

    initial begin
        int ovf_before;
        int tick_before;

        reset_n     = 1'b0;
        i_tick_clk  = 1'b0;
        i_run_btn   = 1'b0;
        i_clear_btn = 1'b0;
        i_lap_btn   = 1'b0;

        // 1: reset held while the divider toggles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i % 2 == 0) i_tick_clk = ~i_tick_clk;
            if (i % 5 == 4)
                chk("rst_outs", 32'({o_tenths, o_sec, o_min, o_running, o_tick, o_overflow}), 0);
        end
        chk("rst_no_tick", 32'(tick_cnt), 0);
        i_tick_clk = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_no_tick", 32'(tick_cnt), 0);

        // 2: latency from i_tick_clk rise to o_tick, in IDLE
        @(posedge clk);
        #1;
        i_tick_clk = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("lat_cyc%0d", k), 32'(o_tick), (k == 3) ? 1 : 0);
        end
        i_tick_clk = 1'b0;
        repeat (4) @(negedge clk);
        chk_time("lat_idle_time", 0, 0, 0);
        chk("lat_idle_run", 32'(o_running), 0);

        // 3: run, count, pause, resume
        do_event(1'b0, 1'b1, 1'b0, 1'b0, "run1", 1'b1);
        ticks(25, "cnt25");
        chk_time("cnt25_time", 0, 2, 5);
        chk("cnt25_running", 32'(o_running), 1);
        do_event(1'b0, 1'b1, 1'b0, 1'b0, "pause", 1'b1);
        ticks(5, "paused");
        chk_time("paused_time", 0, 2, 5);
        chk("paused_running", 32'(o_running), 0);
        do_event(1'b0, 1'b1, 1'b0, 1'b0, "resume", 1'b1);
        ticks(1, "resume1");
        chk_time("resume_time", 0, 2, 6);

        // 5: collisions
        ticks(73, "to_9_9");
        chk_time("at_9_9", 0, 9, 9);
        do_event(1'b1, 1'b0, 1'b1, 1'b0, "clr_tick", 1'b1);
        chk_time("clr_tick_time", 0, 0, 0);
        chk("clr_tick_running", 32'(o_running), 0);
        do_event(1'b0, 1'b1, 1'b0, 1'b0, "run2", 1'b1);
        ticks(3, "to_0_3");
        do_event(1'b1, 1'b1, 1'b0, 1'b0, "run_tick", 1'b1);
        chk_time("run_tick_time", 0, 0, 4);
        chk("run_tick_running", 32'(o_running), 0);
        do_event(1'b1, 1'b1, 1'b0, 1'b0, "pause_run_tick", 1'b1);
        chk_time("pause_run_tick_time", 0, 0, 4);
        chk("pause_run_tick_running", 32'(o_running), 1);

        // 4: wrap at MAX_MIN:59.9
        do_event(1'b0, 1'b0, 1'b1, 1'b0, "clr2", 1'b1);
        do_event(1'b0, 1'b1, 1'b0, 1'b0, "run3", 1'b1);
        ovf_before = ovf_cnt;
        ticks(1199, "wrap");
        chk_time("pre_wrap", MAX_MIN, 59, 9);
        chk("pre_wrap_ovf_cnt", 32'(ovf_cnt - ovf_before), 0);
        do_event(1'b1, 1'b0, 1'b0, 1'b0, "wrap_edge", 1'b1);
        chk_time("wrap_time", 0, 0, 0);
        chk("wrap_ovf_cnt", 32'(ovf_cnt - ovf_before), 1);
        ticks(2, "post_wrap");
        chk_time("post_wrap_time", 0, 0, 2);

        // 6: lap
        do_event(1'b0, 1'b0, 1'b1, 1'b0, "clr3", 1'b1);
        do_event(1'b0, 1'b1, 1'b0, 1'b0, "run4", 1'b1);
        ticks(10, "to_1_0");
        do_event(1'b0, 1'b0, 1'b0, 1'b1, "lap1", 1'b1);
        ticks(30, "lap_hold");
`ifdef STOPWATCH_LAP_EN
        chk_time("lap_frozen", 0, 1, 0);
`else
        chk_time("lap_ignored", 0, 4, 0);
`endif
        do_event(1'b0, 1'b0, 1'b0, 1'b1, "lap2", 1'b1);
        chk_time("lap_release", 0, 4, 0);

        // Async reset mid-count with the wave high across release
        tick_before = tick_cnt;
        @(negedge clk);
        i_tick_clk = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_outs", 32'({o_tenths, o_sec, o_min, o_running, o_overflow}), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_no_tick", 32'(tick_cnt - tick_before), 0);
        chk_time("arst_time", 0, 0, 0);
        chk("arst_running", 32'(o_running), 0);
        i_tick_clk = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
